// File: rtl/sr_data_mem.sv
// Data memory for the single-cycle core: byte-lane RAM plus GPIO, cycle counter and console FIFO.
// Build option: define SR_DATA_MEM_CONSOLE_EN to include the console transmit FIFO.
module sr_data_mem #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  write_byte_en,
    input  logic [31:0] raddr,
    output logic [31:0] rdata,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        misaligned_err
);
    localparam logic [29:0] GPIO_IDX    = 30'h2000_0000;
    localparam logic [29:0] CONSOLE_IDX = 30'h2000_0001;
    localparam logic [29:0] CYCLE_IDX   = 30'h2000_0002;

    logic [31:0] mem [0:(1 << ADDR_W) - 1];
    logic [31:0] gpioReg;
    logic [31:0] cycleReg;
    logic        misalignedReg;
    logic [31:0] consoleStatus;
    logic [31:0] readWord;

    logic        storeEn;
    logic        misaligned;
    logic        storeOk;
    logic        ramWr;
    logic        mmioWr;
    logic        gpioWr;
    logic        cycleWr;
    logic        consoleWr;
    logic [3:0]  laneMask;
    logic [31:0] laneData;

    function automatic logic [3:0] laneMaskF(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'b01:   m = 4'b0001 << lo;
            2'b10:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b11:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate the right-aligned store data so every lane the mask enables sees its bytes.
    function automatic logic [31:0] laneDataF(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b01:   r = {4{d[7:0]}};
            2'b10:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    assign storeEn    = (write_byte_en != 2'b00);
    assign misaligned = ((write_byte_en == 2'b10) && waddr[0]) ||
                        ((write_byte_en == 2'b11) && (waddr[1:0] != 2'b00));
    assign storeOk    = storeEn && !misaligned;
    assign ramWr      = storeOk && !waddr[31];
    assign mmioWr     = storeOk && waddr[31];
    assign gpioWr     = mmioWr && (waddr[31:2] == GPIO_IDX);
    assign cycleWr    = mmioWr && (waddr[31:2] == CYCLE_IDX) && (write_byte_en == 2'b11);
    assign consoleWr  = mmioWr && (waddr[31:2] == CONSOLE_IDX);
    assign laneMask   = laneMaskF(write_byte_en, waddr[1:0]);
    assign laneData   = laneDataF(write_byte_en, wdata);

    // RAM byte-lane writes; RAM is not reset, so stores land even while rst is high
    always_ff @(posedge clk) begin
        if (ramWr) begin
            for (int i = 0; i < 4; i++) begin
                if (laneMask[i]) begin
                    mem[waddr[ADDR_W+1:2]][8*i +: 8] <= laneData[8*i +: 8];
                end
            end
        end
    end

    // GPIO, cycle counter and sticky misalignment flag
    always_ff @(posedge clk) begin
        if (rst) begin
            gpioReg       <= 32'h0000_0000;
            cycleReg      <= 32'h0000_0000;
            misalignedReg <= 1'b0;
        end else begin
            if (gpioWr) begin
                for (int i = 0; i < 4; i++) begin
                    if (laneMask[i]) begin
                        gpioReg[8*i +: 8] <= laneData[8*i +: 8];
                    end
                end
            end
            if (cycleWr) begin
                cycleReg <= wdata;
            end else begin
                cycleReg <= cycleReg + 32'd1;
            end
            if (storeEn && misaligned) begin
                misalignedReg <= 1'b1;
            end
        end
    end

`ifdef SR_DATA_MEM_CONSOLE_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       fifoMem [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             overflowReg;
    logic             emptyS;
    logic             fullS;
    logic             deq;
    logic             accept;

    assign emptyS = (count == {(PTR_W + 1){1'b0}});
    assign fullS  = (count == DEPTH_C);
    assign deq    = !emptyS && tx_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign accept = consoleWr && (!fullS || deq);

    // FIFO storage
    always_ff @(posedge clk) begin
        if (accept) begin
            fifoMem[wrPtr] <= wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr       <= {PTR_W{1'b0}};
            rdPtr       <= {PTR_W{1'b0}};
            count       <= {(PTR_W + 1){1'b0}};
            overflowReg <= 1'b0;
        end else begin
            if (accept) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (deq) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({accept, deq})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (consoleWr && !accept) begin
                overflowReg <= 1'b1;
            end
        end
    end

    assign tx_valid      = !emptyS;
    assign tx_data       = emptyS ? 8'h00 : fifoMem[rdPtr];
    assign consoleStatus = {29'h0000_0000, overflowReg, fullS, emptyS};
`else
    // Without the console, tx_ready has no consumer and the status always reads empty.
    assign tx_valid      = 1'b0;
    assign tx_data       = 8'h00;
    assign consoleStatus = {31'h0000_0000, 1'b1 | (tx_ready & consoleWr & 1'b0)};
`endif

    // Load path: select the word, then align the addressed byte to bit 0
    always_comb begin
        readWord = 32'h0000_0000;
        if (!raddr[31]) begin
            readWord = mem[raddr[ADDR_W+1:2]];
        end else begin
            case (raddr[31:2])
                GPIO_IDX:    readWord = gpioReg;
                CONSOLE_IDX: readWord = consoleStatus;
                CYCLE_IDX:   readWord = cycleReg;
                default:     readWord = 32'h0000_0000;
            endcase
        end
        rdata = readWord >> {raddr[1:0], 3'b000};
    end

    assign gpio_out       = gpioReg;
    assign misaligned_err = misalignedReg;

endmodule

// File: tb/tb_sr_data_mem.sv
// Scoreboard bench for sr_data_mem: stimulus queues expectations, negedge monitors compare.
module tb_sr_data_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  write_byte_en;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        misaligned_err;

    sr_data_mem dut (
        .clk(clk), .rst(rst), .write_byte_en(write_byte_en),
        .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata),
        .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    localparam int SEL_RDATA = 0, SEL_GPIO = 1, SEL_MIS = 2, SEL_TXV = 3, SEL_TXD = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t       expQ[$];
    logic [7:0] txQ[$];
    int         nChecks = 0;
    int         nFail = 0;

    // Output monitor: compare every queued expectation against the DUT at the negedge
    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            chk_t        c;
            logic [31:0] obs;
            c = expQ.pop_front();
            case (c.sel)
                SEL_RDATA: obs = rdata;
                SEL_GPIO:  obs = gpio_out;
                SEL_MIS:   obs = {31'h0, misaligned_err};
                SEL_TXV:   obs = {31'h0, tx_valid};
                SEL_TXD:   obs = {24'h0, tx_data};
                default:   obs = 32'hxxxx_xxxx;
            endcase
            nChecks++;
            if (obs !== c.exp) begin
                nFail++;
                $display("FAIL %s: got %h, expected %h", c.name, obs, c.exp);
            end
        end
    end

    // Sink monitor: each accepted console byte must match the next expected byte
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            nChecks++;
            if (txQ.size() == 0) begin
                nFail++;
                $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
            end else begin
                logic [7:0] e;
                e = txQ.pop_front();
                if (tx_data !== e) begin
                    nFail++;
                    $display("FAIL tx_byte: got %h, expected %h", tx_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        expQ.push_back(c);
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        write_byte_en = size;
        waddr = a;
        wdata = d;
        step();
        write_byte_en = 2'b00;
    endtask

    task automatic load(input string name, input logic [31:0] a, input logic [31:0] exp);
        raddr = a;
        chk(name, SEL_RDATA, exp);
        step();
    endtask

    task automatic loadStore(input string name, input logic [31:0] ra, input logic [31:0] exp,
                             input logic [1:0] size, input logic [31:0] wa, input logic [31:0] d);
        raddr = ra;
        chk(name, SEL_RDATA, exp);
        store(size, wa, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        write_byte_en = 2'b00;
        raddr = 32'h0;
        waddr = 32'h0;
        wdata = 32'h0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_gpio", SEL_GPIO, 32'h0);
        chk("rst_mis", SEL_MIS, 32'h0);
        chk("rst_txv", SEL_TXV, 32'h0);
        chk("rst_txd", SEL_TXD, 32'h0);
        load("rst_cycle", 32'h8000_0008, 32'h0);
        load("rst_status", 32'h8000_0004, 32'h1);

        // RAM byte lanes, halves and aliasing
        store(2'b11, 32'h10, 32'h1122_3344);
        store(2'b01, 32'h12, 32'h0000_00AA);
        load("ram_word", 32'h10, 32'h11AA_3344);
        load("ram_off2", 32'h12, 32'h0000_11AA);
        load("ram_off1", 32'h11, 32'h0011_AA33);
        store(2'b11, 32'h14, 32'h0);
        store(2'b10, 32'h16, 32'h0000_5566);
        load("ram_half", 32'h14, 32'h5566_0000);
        load("ram_half_off", 32'h16, 32'h0000_5566);
        load("ram_alias", 32'h1010, 32'h11AA_3344);
        load("ram_alias_b30", 32'h4000_0010, 32'h11AA_3344);
        loadStore("ram_rw_old", 32'h10, 32'h11AA_3344, 2'b11, 32'h10, 32'hCAFE_F00D);
        load("ram_rw_new", 32'h10, 32'hCAFE_F00D);

        // Misaligned stores are suppressed and latch the flag
        store(2'b11, 32'h20, 32'h0102_0304);
        chk("mis_before", SEL_MIS, 32'h0);
        store(2'b11, 32'h21, 32'hDEAD_BEEF);
        chk("mis_set", SEL_MIS, 32'h1);
        load("mis_ram_kept", 32'h20, 32'h0102_0304);
        store(2'b10, 32'h8000_0001, 32'h0000_FFFF);
        chk("mis_gpio_kept", SEL_GPIO, 32'h0);
        step();

        // GPIO
        store(2'b10, 32'h8000_0002, 32'h0000_BEEF);
        chk("gpio_half", SEL_GPIO, 32'hBEEF_0000);
        load("gpio_read", 32'h8000_0000, 32'hBEEF_0000);
        load("gpio_read_off", 32'h8000_0002, 32'h0000_BEEF);
        store(2'b01, 32'h8000_0001, 32'h0000_005A);
        chk("gpio_byte", SEL_GPIO, 32'hBEEF_5A00);
        step();
        store(2'b11, 32'h8000_0000, 32'h0000_0005);
        chk("gpio_word", SEL_GPIO, 32'h0000_0005);
        step();

        // CYCLE load, wrap, and ignored narrow stores
        store(2'b11, 32'h8000_0008, 32'hFFFF_FFFE);
        load("cyc_x", 32'h8000_0008, 32'hFFFF_FFFE);
        load("cyc_x1", 32'h8000_0008, 32'hFFFF_FFFF);
        load("cyc_wrap", 32'h8000_0008, 32'h0000_0000);
        store(2'b11, 32'h8000_0008, 32'h0000_0100);
        loadStore("cyc_byte_st", 32'h8000_0008, 32'h0000_0100, 2'b01, 32'h8000_0008, 32'h77);
        load("cyc_byte_ign", 32'h8000_0008, 32'h0000_0101);

        // Unmapped MMIO
        store(2'b11, 32'h8000_000C, 32'hFFFF_FFFF);
        load("mmio_unmapped", 32'h8000_000C, 32'h0);
        load("mmio_unmapped2", 32'h8000_0010, 32'h0);

`ifdef SR_DATA_MEM_CONSOLE_EN
        // Overflow: five bytes into a four-entry FIFO with the sink stalled
        store(2'b01, 32'h8000_0004, 32'h41);
        store(2'b10, 32'h8000_0004, 32'h42);
        store(2'b11, 32'h8000_0004, 32'h43);
        store(2'b01, 32'h8000_0004, 32'h44);
        store(2'b01, 32'h8000_0004, 32'h45);
        chk("fifo_txv_full", SEL_TXV, 32'h1);
        chk("fifo_head", SEL_TXD, 32'h41);
        load("fifo_status_ovf", 32'h8000_0004, 32'h6);
        chk("fifo_head_held", SEL_TXD, 32'h41);
        step();
        txQ.push_back(8'h41);
        txQ.push_back(8'h42);
        txQ.push_back(8'h43);
        txQ.push_back(8'h44);
        tx_ready = 1'b1;
        repeat (4) step();
        chk("fifo_drained", SEL_TXV, 32'h0);
        load("fifo_status_empty", 32'h8000_0004, 32'h5);
`else
        store(2'b01, 32'h8000_0004, 32'h41);
        chk("noconsole_txv", SEL_TXV, 32'h0);
        load("noconsole_status", 32'h8000_0004, 32'h1);
`endif

        // Reset mid-operation with bytes queued; the RAM store in the reset cycle still lands
        tx_ready = 1'b0;
        store(2'b01, 32'h8000_0004, 32'h58);
        store(2'b01, 32'h8000_0004, 32'h59);
        store(2'b01, 32'h8000_0004, 32'h57);
        chk("pre_rst_gpio", SEL_GPIO, 32'h5);
        chk("pre_rst_mis", SEL_MIS, 32'h1);
        step();
        rst = 1'b1;
        store(2'b11, 32'h30, 32'h1234_5678);
        rst = 1'b0;
        chk("post_rst_gpio", SEL_GPIO, 32'h0);
        chk("post_rst_txv", SEL_TXV, 32'h0);
        chk("post_rst_txd", SEL_TXD, 32'h0);
        chk("post_rst_mis", SEL_MIS, 32'h0);
        load("post_rst_cycle", 32'h8000_0008, 32'h0);
        load("post_rst_status", 32'h8000_0004, 32'h1);
        load("post_rst_ram", 32'h10, 32'hCAFE_F00D);
        load("rst_cycle_ram_wr", 32'h30, 32'h1234_5678);

`ifdef SR_DATA_MEM_CONSOLE_EN
        // Full FIFO with a simultaneous dequeue accepts the new byte
        store(2'b01, 32'h8000_0004, 32'h50);
        store(2'b01, 32'h8000_0004, 32'h51);
        store(2'b01, 32'h8000_0004, 32'h52);
        store(2'b01, 32'h8000_0004, 32'h53);
        load("full_status", 32'h8000_0004, 32'h2);
        txQ.push_back(8'h50);
        txQ.push_back(8'h51);
        txQ.push_back(8'h52);
        txQ.push_back(8'h53);
        txQ.push_back(8'h5A);
        tx_ready = 1'b1;
        store(2'b01, 32'h8000_0004, 32'h5A);
        load("full_deq_status", 32'h8000_0004, 32'h2);
        repeat (3) step();
        chk("full_deq_drained", SEL_TXV, 32'h0);
        load("full_deq_final", 32'h8000_0004, 32'h1);
        tx_ready = 1'b0;
`endif

        repeat (2) step();
        nChecks++;
        if (txQ.size() != 0) begin
            nFail++;
            $display("FAIL tx_leftover: got %0d undelivered bytes, expected 0", txQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
